// File: rtl/alu_mc_seq.sv
// rtl/alu_mc_seq.sv - issue/collect controller for a free-running multi-cycle ALU
// Credit-gated issue, STAGES-deep valid tracking and a result FIFO with registered head.

module alu_mc_seq #(
    parameter int STAGES = 3,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_sel,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_c,
    output logic        alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_c,
    input  logic [31:0] alu_r,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy
);

    localparam int CW = AW + 1;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];

    logic fire;
    logic capture;
    logic pop;

    // req_ready depends only on registered credits, never on req_valid or res_ready
    assign req_ready = (credits_q != '0);
    assign fire      = req_valid & req_ready;
    assign res_valid = (count_q != '0);
    assign pop       = res_valid & res_ready;
    assign capture   = vld_q[STAGES-1];
    assign res_data  = mem_q[rd_ptr_q];
    assign busy      = (|vld_q) | res_valid;

    assign alu_sel = fire ? req_sel : 1'b0;
    assign alu_a   = fire ? req_a   : 32'd0;
    assign alu_b   = fire ? req_b   : 32'd0;
    assign alu_c   = fire ? req_c   : 1'b0;

    always_comb begin
        vld_d    = '0;
        vld_d[0] = fire;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
        end

        mem_d = mem_q;
        if (capture) begin
            mem_d[wr_ptr_q] = alu_r;
        end

        wr_ptr_d  = wr_ptr_q + AW'(capture);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + CW'(capture) - CW'(pop);
        // Capture is credit-neutral: the slot was reserved when the op fired
        credits_d = credits_q - CW'(fire) + CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q     <= '0;
            count_q   <= '0;
            credits_q <= CW'(DEPTH);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            vld_q     <= vld_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
